// File: rtl/fp_div_round_pack_if.sv
// Handshake bundle between the mantissa divider and the FP32 round/pack stage.
// master drives the beats and out_ready; slave is the round/pack pipeline.
interface fp_div_round_pack_if #(parameter int FLAG_W = 5);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [9:0]        in_exp;
  logic [25:0]       in_quot;
  logic              in_rem_nz;
  logic [2:0]        in_special;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [FLAG_W-1:0] out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_quot, in_rem_nz, in_special, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_quot, in_rem_nz, in_special, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_div_round_pack.sv
// FP32 divide post-processing: normalise, round-to-nearest-even, pack, flag.
// Default build flushes tiny results to zero; FP_DIV_DENORM_EN enables gradual underflow.
module fp_div_round_pack #(parameter int FLAG_W = 5) (
  input logic            clk,
  input logic            rst,
  fp_div_round_pack_if.slave io
);
  localparam int NV = 4, DZ = 3, OF = 2, UF = 1, NX = 0;

  logic adv1, adv2, s1_valid, s2_valid;
  assign adv2        = !s2_valid || io.out_ready;
  assign adv1        = !s1_valid || adv2;
  assign io.in_ready = adv1;
  assign io.out_valid = s2_valid;

  // stage 1: normalise the 1.25 quotient into 1.23 + guard + sticky
  logic signed [10:0] e_in, e0, n_e;
  logic [22:0]        m0, n_mant;
  logic               g0, s0, n_g, n_s;
  assign e_in = {io.in_exp[9], io.in_exp};

  always_comb begin
    if (io.in_quot[25]) begin
      m0 = io.in_quot[24:2]; g0 = io.in_quot[1]; s0 = io.in_quot[0] | io.in_rem_nz; e0 = e_in;
    end else begin
      m0 = io.in_quot[23:1]; g0 = io.in_quot[0]; s0 = io.in_rem_nz;               e0 = e_in - 11'sd1;
    end
  end

`ifdef FP_DIV_DENORM_EN
  logic [10:0] sh_raw;
  logic [4:0]  shm1;
  logic [48:0] wide;
  logic        n_tiny, s1_tiny;
  // {1,m,g} is pre-shifted by one so a shift of (1-e) becomes (shm1 = shift-1), clamped at 25
  always_comb begin
    sh_raw = 11'd1 - $unsigned(e0);
    shm1   = (sh_raw > 11'd25) ? 5'd24 : sh_raw[4:0] - 5'd1;
    wide   = {1'b1, m0, g0, 24'b0} >> shm1;
    if (e0 <= 11'sd0) begin
      n_mant = wide[48:26]; n_g = wide[25]; n_s = s0 | (|wide[24:0]); n_e = '0; n_tiny = 1'b1;
    end else begin
      n_mant = m0; n_g = g0; n_s = s0; n_e = e0; n_tiny = 1'b0;
    end
  end
  always_ff @(posedge clk) if (adv1 && io.in_valid) s1_tiny <= n_tiny;
`else
  assign n_mant = m0;
  assign n_g    = g0;
  assign n_s    = s0;
  assign n_e    = e0;
`endif

  logic               s1_sign, s1_g, s1_s;
  logic [2:0]         s1_special;
  logic signed [10:0] s1_e;
  logic [22:0]        s1_mant;

  always_ff @(posedge clk) begin
    if (adv1 && io.in_valid) begin
      s1_sign    <= io.in_sign;
      s1_special <= io.in_special;
      s1_mant    <= n_mant;
      s1_g       <= n_g;
      s1_s       <= n_s;
      s1_e       <= n_e;
    end
  end

  // stage 2: RNE, carry-out bumps the exponent (mantissa field wraps to zero)
  logic               inc, nx;
  logic [23:0]        sum;
  logic signed [10:0] e_r, carry_e;
  logic [22:0]        mant_r;
  logic [31:0]        res_n, res_q;
  logic [FLAG_W-1:0]  flg_n, flg_q;

  assign inc     = s1_g & (s1_s | s1_mant[0]);
  assign sum     = {1'b0, s1_mant} + {23'b0, inc};
  assign carry_e = {10'b0, sum[23]};
  assign e_r     = s1_e + carry_e;
  assign mant_r  = sum[22:0];
  assign nx      = s1_g | s1_s;

  always_comb begin
    res_n = '0;
    flg_n = '0;
    case (s1_special)
      3'd0: begin
        if (e_r >= 11'sd255) begin
          res_n = {s1_sign, 8'hFF, 23'b0};
          flg_n[OF] = 1'b1;
          flg_n[NX] = 1'b1;
`ifdef FP_DIV_DENORM_EN
        end else if (s1_tiny) begin
          res_n = {s1_sign, e_r[7:0], mant_r};
          flg_n[UF] = nx;
          flg_n[NX] = nx;
`else
        end else if (e_r <= 11'sd0) begin
          res_n = {s1_sign, 31'b0};
          flg_n[UF] = 1'b1;
          flg_n[NX] = 1'b1;
`endif
        end else begin
          res_n = {s1_sign, e_r[7:0], mant_r};
          flg_n[NX] = nx;
        end
      end
      3'd2: res_n = {s1_sign, 8'hFF, 23'b0};
      3'd3: res_n = {s1_sign, 31'b0};
      3'd4: begin
        res_n = {s1_sign, 8'hFF, 23'b0};
        flg_n[DZ] = 1'b1;
      end
      default: begin
        res_n = 32'h7FC0_0000;
        flg_n[NV] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
    end else begin
      if (adv1) s1_valid <= io.in_valid;
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          res_q <= res_n;
          flg_q <= flg_n;
        end
      end
    end
  end

  assign io.out_result = res_q;
  assign io.out_flags  = flg_q;
endmodule

// File: tb/tb_fp_div_round_pack.sv
// Directed-vector bench for fp_div_round_pack with a queue scoreboard and
// an independent output monitor.
module tb_fp_div_round_pack;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_div_round_pack_if bus();
  fp_div_round_pack dut (.clk(clk), .rst(rst), .io(bus));

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // monitor: every transferred output beat is compared against the scoreboard head
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h with no expected beat", bus.out_result);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("result", {32'b0, bus.out_result}, {32'b0, e[36:5]});
        chk("flags",  {59'b0, bus.out_flags},  {59'b0, e[4:0]});
      end
    end
  end

  // drive a beat at posedge+1, wait for acceptance, push the expectation
  task automatic send(input logic sg, input logic [9:0] ex, input logic [25:0] q,
                      input logic rz, input logic [2:0] sp,
                      input logic [31:0] er, input logic [4:0] ef);
    bus.in_valid = 1'b1; bus.in_sign = sg; bus.in_exp = ex;
    bus.in_quot = q; bus.in_rem_nz = rz; bus.in_special = sp;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back({er, ef});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL accept_timeout: got in_ready=0 expected in_ready=1 within 50 cycles");
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_quot = '0;
    bus.in_rem_nz = 1'b0; bus.in_special = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_result",    {32'b0, bus.out_result}, 64'd0);
    chk("rst_flags",     {59'b0, bus.out_flags}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 6.0/2.0 with latency check
    send(1'b0, 10'd128, 26'h3000000, 1'b0, 3'd0, 32'h4040_0000, 5'b00000);
    chk("lat_cycle1", {63'b0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_cycle2", {63'b0, bus.out_valid}, 64'd1);

    // back-to-back directed vectors
    send(1'b0, 10'd127, 26'h1555555, 1'b1, 3'd0, 32'h3F2A_AAAB, 5'b00001);
    send(1'b0, 10'd127, 26'h3FFFFFF, 1'b0, 3'd0, 32'h4000_0000, 5'b00001);
    send(1'b0, 10'd300, 26'h2000000, 1'b0, 3'd0, 32'h7F80_0000, 5'b00101);
    send(1'b0, 10'd254, 26'h3FFFFFF, 1'b0, 3'd0, 32'h7F80_0000, 5'b00101);
    send(1'b0, 10'd127, 26'h2000002, 1'b0, 3'd0, 32'h3F80_0000, 5'b00001);
    send(1'b0, 10'd127, 26'h2000006, 1'b0, 3'd0, 32'h3F80_0002, 5'b00001);
    send(1'b0, 10'd2,   26'h1000000, 1'b0, 3'd0, 32'h0080_0000, 5'b00000);
`ifdef FP_DIV_DENORM_EN
    send(1'b1, 10'h3F6, 26'h2000000, 1'b0, 3'd0, 32'h8000_1000, 5'b00000);
    send(1'b0, 10'd1,   26'h1000000, 1'b0, 3'd0, 32'h0040_0000, 5'b00000);
`else
    send(1'b1, 10'h3F6, 26'h2000000, 1'b0, 3'd0, 32'h8000_0000, 5'b00011);
    send(1'b0, 10'd1,   26'h1000000, 1'b0, 3'd0, 32'h0000_0000, 5'b00011);
`endif
    send(1'b1, 10'd127, 26'h2000000, 1'b1, 3'd4, 32'hFF80_0000, 5'b01000);
    send(1'b0, 10'd127, 26'h2000000, 1'b1, 3'd1, 32'h7FC0_0000, 5'b10000);
    send(1'b1, 10'd127, 26'h2000000, 1'b0, 3'd7, 32'h7FC0_0000, 5'b10000);
    send(1'b0, 10'd127, 26'h2000000, 1'b1, 3'd2, 32'h7F80_0000, 5'b00000);
    send(1'b1, 10'd127, 26'h2000000, 1'b1, 3'd3, 32'h8000_0000, 5'b00000);
    repeat (4) @(posedge clk);
    #1;

    // backpressure: two beats accepted, third stalls with first result held
    bus.out_ready = 1'b0;
    send(1'b0, 10'd128, 26'h3000000, 1'b0, 3'd0, 32'h4040_0000, 5'b00000);
    send(1'b0, 10'd127, 26'h1555555, 1'b1, 3'd0, 32'h3F2A_AAAB, 5'b00001);
    bus.in_valid = 1'b1; bus.in_sign = 1'b1; bus.in_exp = 10'd127;
    bus.in_quot = 26'h2000000; bus.in_rem_nz = 1'b0; bus.in_special = 3'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'b0, bus.in_ready}, 64'd0);
      chk("stall_valid",    {63'b0, bus.out_valid}, 64'd1);
      chk("stall_result",   {32'b0, bus.out_result}, 64'h4040_0000);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain_in_ready", {63'b0, bus.in_ready}, 64'd1);
    exp_q.push_back({32'hFF80_0000, 5'b01000});
    chk("drain_valid0", {63'b0, bus.out_valid}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk("drain_valid", {63'b0, bus.out_valid}, 64'd1);
    end
    @(posedge clk); #1;

    // reset during a stall discards in-flight beats
    bus.out_ready = 1'b0;
    send(1'b0, 10'd300, 26'h2000000, 1'b0, 3'd0, 32'h7F80_0000, 5'b00101);
    send(1'b0, 10'd128, 26'h3000000, 1'b0, 3'd0, 32'h4040_0000, 5'b00000);
    @(negedge clk);
    chk("pre_rst_valid", {63'b0, bus.out_valid}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("mid_rst_valid",  {63'b0, bus.out_valid}, 64'd0);
    chk("mid_rst_result", {32'b0, bus.out_result}, 64'd0);
    chk("mid_rst_flags",  {59'b0, bus.out_flags}, 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", {63'b0, bus.out_valid}, 64'd0);

    // one more beat after reset to show the pipe is live again
    send(1'b0, 10'd127, 26'h3FFFFFF, 1'b0, 3'd0, 32'h4000_0000, 5'b00001);
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_div_round_pack.md
Name: fp_div_round_pack

Overview:
- Post-processing stage placed directly downstream of the iterative mantissa divider in the FP32 divide path.
- Takes the raw quotient mantissa, a sticky remainder flag, sign, pre-normalisation exponent and an upstream special-case code.
- Normalises, rounds to nearest-even, detects overflow/underflow and packs an IEEE-754 single-precision word with exception flags.
- Two-stage pipeline with valid/ready backpressure.

Parameters:
- FLAG_W, 5, width of exception flag vector (fixed encoding; not to be changed).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_sign  in  1  result sign (signA ^ signB).
- in_exp  in  10  two's-complement biased exponent before normalisation: expA - expB + 127.
- in_quot  in  26  quotient fixed-point 1.25; value in [0.5, 2); in_quot[25] is the integer bit.
- in_rem_nz  in  1  divider remainder non-zero (sticky).
- in_special  in  3  0 normal, 1 NaN/invalid, 2 infinity, 3 zero, 4 divide-by-zero; 5..7 treated as 1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_result  out  32  packed FP32 result.
- out_flags  out  5  [4] NV, [3] DZ, [2] OF, [1] UF, [0] NX.

Behaviour:
- Reset (rst=1 at posedge): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_flags=0. Reset mid-operation discards all in-flight beats.
- Handshake:
  - Beat transfers when valid && ready.
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1, combinational from out_ready.
  - out_result and out_flags are held stable while out_valid && !out_ready.
- Throughput and latency: full throughput (one beat per cycle); latency 2 cycles with no stall.
- Stage 1 (normalise):
  - in_quot[25]=1: mant = q[24:2], G = q[1], S = q[0] | rem_nz, e = in_exp.
  - in_quot[25]=0: mant = q[23:1], G = q[0], S = rem_nz, e = in_exp - 1.
  - Special code, sign and (denormal path only) shifted fields are registered alongside.
- Stage 2 (round and pack):
  - RNE: inc = G & (S | mant[0]).
  - {carry, mant'} = mant + inc. If carry: mant' = 0, e = e + 1.
  - NX = G | S.
  - Exponent arithmetic is 11-bit signed; no wrap-around permitted.
  - Overflow, e >= 255: result {sign, 8'hFF, 0}, OF|NX set.
  - Underflow, e <= 0: see Optional Feature.
  - Otherwise: {sign, e[7:0], mant'}.
- Special codes (override the arithmetic path; NX not set):
  - NaN: 0x7FC00000, NV.
  - Infinity: {sign, 0xFF, 0}, no flags.
  - Zero: {sign, 0}, no flags.
  - Divide-by-zero: {sign, 0xFF, 0}, DZ.
- No FSM; the pipeline is two valid-bit registers with enables adv1/adv2.

Optional Feature:
- Macro: FP_DIV_DENORM_EN.
- Defined, gradual underflow: stage 1 computes shift = 1 - e when e <= 0, and right-shifts {1, mant} by that shift. Shifted-out bits are ORed into S and the new G is taken from the shift. Shift is clamped at 25; beyond the clamp everything goes to sticky. Exponent field = 0. RNE is then applied. If rounding carries into bit 23, the exponent field becomes 1 (smallest normal). UF is set when the result is tiny before rounding and NX=1.
- Undefined, flush-to-zero: e <= 0 yields {sign, 0}, UF|NX.
- In both builds, subnormal inputs are the upstream stage's responsibility.

Test Plan:
- 6.0/2.0: sign 0, exp 128, quot 26'h3000000, rem_nz 0, special 0 -> 0x40400000, flags 0, out_valid 2 cycles after accept.
- 1.0/1.5: exp 127, quot 26'h1555555, rem_nz 1 -> 0x3F2AAAAB, flags 5'b00001.
- Mantissa carry: exp 127, quot 26'h3FFFFFF, rem_nz 0 -> 0x40000000, NX.
- Overflow: exp 300, quot 26'h2000000 -> 0x7F800000, OF|NX.
- Underflow and special: exp -10, sign 1, FTZ build -> 0x80000000, UF|NX. special=4, sign 1 -> 0xFF800000, DZ. special=1 -> 0x7FC00000, NV.
- Backpressure: out_ready=0, three back-to-back valid inputs -> two accepted, then in_ready=0 with first result held stable. Raising out_ready drains the results in order, one per cycle. rst=1 during the stall -> out_valid=0 next cycle.
